// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: operand-forward select codes and MUL/DIV scoreboard states.
package riscv_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_MD = 2'b11;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/riscv_hazard_scoreboard_if.sv
// Decode/execute/memory/writeback hazard signals exchanged between datapath and hazard unit.
interface riscv_hazard_scoreboard_if #(
  parameter int unsigned REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] Rs1D, Rs2D, RdD;
  logic                  Rs1UsedD, Rs2UsedD, RegWriteD, MdOpD;
  logic [REG_ADDR_W-1:0] Rs1E, Rs2E, RdE;
  logic                  ResultSrcE0, RegWriteE, MdStartE;
  logic [REG_ADDR_W-1:0] RdM, RdW;
  logic                  RegWriteM, RegWriteW;
  logic                  PCSrcE, MdDone;
  logic                  StallF, StallD, FlushD, FlushE;
  logic [1:0]            ForwardAE, ForwardBE;
  logic                  MdBusy, MdError;

  modport master (
    output Rs1D, Rs2D, RdD, Rs1UsedD, Rs2UsedD, RegWriteD, MdOpD,
    output Rs1E, Rs2E, RdE, ResultSrcE0, RegWriteE, MdStartE,
    output RdM, RdW, RegWriteM, RegWriteW, PCSrcE, MdDone,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, MdBusy, MdError
  );

  modport slave (
    input  Rs1D, Rs2D, RdD, Rs1UsedD, Rs2UsedD, RegWriteD, MdOpD,
    input  Rs1E, Rs2E, RdE, ResultSrcE0, RegWriteE, MdStartE,
    input  RdM, RdW, RegWriteM, RegWriteW, PCSrcE, MdDone,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, MdBusy, MdError
  );
endinterface

// File: rtl/riscv_md_scoreboard.sv
// One-entry scoreboard for a single outstanding MUL/DIV op, with watchdog and sticky error flag.
module riscv_md_scoreboard
  import riscv_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = $clog2(MD_TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  done_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  output logic                  busy_o,
  output logic [REG_ADDR_W-1:0] md_rd_o,
  output logic                  done_c_o,
  output logic                  error_o
);

  md_state_t             state_q, state_d;
  logic [REG_ADDR_W-1:0] md_rd_q, md_rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;

  // Next state: a start while busy or a done while idle is ignored but flagged.
  always_comb begin
    state_d = state_q;
    md_rd_d = md_rd_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      MD_IDLE: begin
        if (done_i) err_d = 1'b1;
        if (start_i) begin
          state_d = MD_BUSY;
          md_rd_d = rd_i;
          cnt_d   = '0;
        end
      end
      MD_BUSY: begin
        if (start_i) err_d = 1'b1;
        if (done_i) begin
          state_d = MD_IDLE;
        end else if (cnt_q == CNT_W'(MD_TIMEOUT - 1)) begin
          state_d = MD_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      md_rd_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      md_rd_q <= md_rd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign busy_o   = (state_q == MD_BUSY);
  assign md_rd_o  = md_rd_q;
  assign done_c_o = (state_q == MD_BUSY) && done_i;
  assign error_o  = err_q;

endmodule

// File: rtl/riscv_hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline: forwarding selects, load-use/MUL-DIV stalls, branch flushes.
module riscv_hazard_scoreboard
  import riscv_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          FWD_EN     = 1'b1,
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = $clog2(MD_TIMEOUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  riscv_hazard_scoreboard_if.slave  hz
);

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  logic     md_busy, md_done_c, md_error;
  reg_idx_t md_rd;

  riscv_md_scoreboard #(
    .REG_ADDR_W(REG_ADDR_W),
    .MD_TIMEOUT(MD_TIMEOUT),
    .CNT_W     (CNT_W)
  ) u_md (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (hz.MdStartE),
    .done_i  (hz.MdDone),
    .rd_i    (hz.RdE),
    .busy_o  (md_busy),
    .md_rd_o (md_rd),
    .done_c_o(md_done_c),
    .error_o (md_error)
  );

  // x0 is hardwired, so it never creates a dependency.
  function automatic logic idx_hit(reg_idx_t a, reg_idx_t b);
    return (a != '0) && (a == b);
  endfunction

  reg_idx_t   rs_d [2];
  logic       used_d [2];
  reg_idx_t   rs_e [2];
  logic [1:0] fwd_c [2];
  logic       src_hz_c, hz_d_c;

  assign rs_d[0]   = hz.Rs1D;
  assign rs_d[1]   = hz.Rs2D;
  assign used_d[0] = hz.Rs1UsedD;
  assign used_d[1] = hz.Rs2UsedD;
  assign rs_e[0]   = hz.Rs1E;
  assign rs_e[1]   = hz.Rs2E;

  // Per-source RAW hazards seen from decode.
  always_comb begin
    src_hz_c = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (used_d[i]) begin
        if ((hz.ResultSrcE0 || hz.MdStartE) && idx_hit(rs_d[i], hz.RdE)) src_hz_c = 1'b1;
        if (md_busy && !hz.MdDone && idx_hit(rs_d[i], md_rd))            src_hz_c = 1'b1;
        if (!FWD_EN && ((hz.RegWriteE && idx_hit(rs_d[i], hz.RdE)) ||
                        (hz.RegWriteM && idx_hit(rs_d[i], hz.RdM)) ||
                        (hz.RegWriteW && idx_hit(rs_d[i], hz.RdW))))
          src_hz_c = 1'b1;
      end
    end
  end

  assign hz_d_c = src_hz_c
               || (md_busy && hz.RegWriteD && idx_hit(hz.RdD, md_rd))
               || (hz.MdOpD && (md_busy || hz.MdStartE));

  // Execute operand bypass, youngest producer first.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fwd_c[i] = FWD_RF;
      if (FWD_EN) begin
        if (md_done_c && idx_hit(rs_e[i], md_rd))              fwd_c[i] = FWD_MD;
        else if (hz.RegWriteM && idx_hit(rs_e[i], hz.RdM))     fwd_c[i] = FWD_M;
        else if (hz.RegWriteW && idx_hit(rs_e[i], hz.RdW))     fwd_c[i] = FWD_W;
      end
    end
  end

  assign hz.StallF    = rst_n && hz_d_c && !hz.PCSrcE;
  assign hz.StallD    = rst_n && hz_d_c && !hz.PCSrcE;
  assign hz.FlushD    = rst_n && hz.PCSrcE;
  assign hz.FlushE    = rst_n && (hz_d_c || hz.PCSrcE);
  assign hz.ForwardAE = rst_n ? fwd_c[0] : FWD_RF;
  assign hz.ForwardBE = rst_n ? fwd_c[1] : FWD_RF;
  assign hz.MdBusy    = md_busy;
  assign hz.MdError   = md_error;

endmodule
